// File: rtl/net_pkg.sv
// Shared constants and arbiter state type for the ingress arbiter.
// The TAG state exists only when PORT_TAG_EN is defined.
package net_pkg;

   localparam int NET_NUM_PORTS  = 4;
   localparam int NET_DATA_W     = 8;
   localparam int NET_FIFO_DEPTH = 16;

`ifdef PORT_TAG_EN
   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_TAG    = 2'd1,
      ARB_STREAM = 2'd2
   } arb_state_t;
`else
   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_STREAM = 2'd2
   } arb_state_t;
`endif

endpackage

// File: rtl/pkt_fifo.sv
// Synchronous FIFO for one ingress port. The head entry is read combinationally.
// A write becomes visible at the head on the following cycle.
module pkt_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 16
)(
   input  logic             clk,
   input  logic             resetn,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   // A full FIFO refuses writes even if it is being popped this cycle.
   assign w_push    = i_wr_en && !o_full;
   assign w_pop     = i_rd_en && !o_empty;
   assign o_rd_data = r_mem[r_rd_ptr];

   // Storage array; contents are don't-care until pointers make them live.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
   end

   // Pointer and occupancy tracking, cleared by reset to drop any buffered beats.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/network_ingress_arb.sv
// Packet-level round-robin merge of NUM_PORTS ingress byte streams.
// Each port buffers into its own pkt_fifo; a granted port owns the output
// until its last beat transfers. Define PORT_TAG_EN to prefix every packet
// with one beat carrying the source port index.
module network_ingress_arb
   import net_pkg::*;
#(
   parameter int NUM_PORTS  = NET_NUM_PORTS,
   parameter int DATA_W     = NET_DATA_W,
   parameter int FIFO_DEPTH = NET_FIFO_DEPTH
)(
   input  logic                          clk,
   input  logic                          resetn,
   input  logic [NUM_PORTS-1:0]          rx_valid,
   input  logic [NUM_PORTS*DATA_W-1:0]   rx_data,
   input  logic [NUM_PORTS-1:0]          rx_last,
   output logic [NUM_PORTS-1:0]          rx_ready,
   output logic                          tx_valid,
   output logic [DATA_W-1:0]             tx_data,
   output logic                          tx_last,
   input  logic                          tx_ready,
   output logic [$clog2(NUM_PORTS)-1:0]  tx_port
);

   localparam int PW = $clog2(NUM_PORTS);

   logic [NUM_PORTS-1:0]           w_full;
   logic [NUM_PORTS-1:0]           w_empty;
   logic [NUM_PORTS-1:0]           w_pop;
   logic [NUM_PORTS-1:0][DATA_W:0] w_head;

   arb_state_t    r_state;
   logic [PW-1:0] r_grant;
   logic [PW-1:0] r_rr_ptr;
   logic          w_any;
   logic [PW-1:0] w_sel;
   int            w_dist;
   int            w_best;

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
      pkt_fifo #(.WIDTH(DATA_W+1), .DEPTH(FIFO_DEPTH)) u_fifo (
         .clk       (clk),
         .resetn    (resetn),
         .i_wr_en   (rx_valid[g]),
         .i_wr_data ({rx_last[g], rx_data[g*DATA_W +: DATA_W]}),
         .i_rd_en   (w_pop[g]),
         .o_rd_data (w_head[g]),
         .o_full    (w_full[g]),
         .o_empty   (w_empty[g])
      );
   end

   assign rx_ready = ~w_full;

   // Round-robin pick: the non-empty port closest after r_rr_ptr wins.
   always_comb begin
      w_any  = 1'b0;
      w_sel  = '0;
      w_best = NUM_PORTS;
      w_dist = 0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         w_dist = (i + 2*NUM_PORTS - int'(r_rr_ptr) - 1) % NUM_PORTS;
         if (!w_empty[i] && (w_dist < w_best)) begin
            w_best = w_dist;
            w_any  = 1'b1;
            w_sel  = PW'(i);
         end
      end
   end

   // Output mux: only the granted FIFO can drive tx, and only it is popped.
   always_comb begin
      tx_valid = 1'b0;
      tx_data  = '0;
      tx_last  = 1'b0;
      tx_port  = '0;
      w_pop    = '0;
      case (r_state)
         ARB_STREAM: begin
            tx_port         = r_grant;
            tx_valid        = !w_empty[r_grant];
            tx_data         = w_head[r_grant][DATA_W-1:0];
            tx_last         = w_head[r_grant][DATA_W];
            w_pop[r_grant]  = tx_valid && tx_ready;
         end
`ifdef PORT_TAG_EN
         ARB_TAG: begin
            tx_port  = r_grant;
            tx_valid = 1'b1;
            tx_data  = DATA_W'(r_grant);
         end
`endif
         default: ;
      endcase
   end

   // Arbiter FSM: grant in IDLE, hold the grant until the last beat leaves.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state  <= ARB_IDLE;
         r_grant  <= '0;
         r_rr_ptr <= PW'(NUM_PORTS-1);
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (w_any) begin
                  r_grant <= w_sel;
`ifdef PORT_TAG_EN
                  r_state <= ARB_TAG;
`else
                  r_state <= ARB_STREAM;
`endif
               end
            end
`ifdef PORT_TAG_EN
            ARB_TAG: begin
               if (tx_ready) r_state <= ARB_STREAM;
            end
`endif
            ARB_STREAM: begin
               if (tx_valid && tx_ready && tx_last) begin
                  r_rr_ptr <= r_grant;
                  r_state  <= ARB_IDLE;
               end
            end
            default: r_state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_network_ingress_arb.sv
// Self-checking bench for network_ingress_arb: a directed vector table, hand
// sequences for multi-cycle corners, and randomized traffic compared against a
// queue-based packet model. Honours PORT_TAG_EN when it is defined.
module tb_network_ingress_arb;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int D  = 16;
   localparam int PW = 2;
`ifdef PORT_TAG_EN
   localparam int GRANT_MODE = 1;
`else
   localparam int GRANT_MODE = 2;
`endif

   typedef logic [W:0] beat_t;   // {last, data}

   typedef struct {
      logic [N-1:0]   v;
      logic [N*W-1:0] d;
      logic [N-1:0]   l;
      logic           tr;
      logic           ev;
      logic [W-1:0]   ed;
      logic           el;
      logic [PW-1:0]  ep;
   } vec_t;

   logic            clk = 1'b0;
   logic            resetn;
   logic [N-1:0]    rx_valid;
   logic [N*W-1:0]  rx_data;
   logic [N-1:0]    rx_last;
   logic [N-1:0]    rx_ready;
   logic            tx_valid;
   logic [W-1:0]    tx_data;
   logic            tx_last;
   logic            tx_ready;
   logic [PW-1:0]   tx_port;

   network_ingress_arb #(.NUM_PORTS(N), .DATA_W(W), .FIFO_DEPTH(D)) dut (
      .clk      (clk),
      .resetn   (resetn),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .rx_last  (rx_last),
      .rx_ready (rx_ready),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .tx_last  (tx_last),
      .tx_ready (tx_ready),
      .tx_port  (tx_port)
   );

   always #5 clk = ~clk;

   int     checks = 0;
   int     errors = 0;

   // reference model: beats accepted into each port, packet-level arbiter
   beat_t  q[N][$];
   int     m_mode;      // 0 idle, 1 tag beat pending, 2 streaming
   int     m_g;
   int     m_rr;
   // source side: beats still to be offered on each port
   beat_t  src[N][$];
   logic [N-1:0] acc;
   int     order_q[$];
   bit     in_pkt;
   int     tx_cnt;
   logic   prev_v, prev_r, prev_l;
   logic [W-1:0] prev_d;
   vec_t   tbl[7];
   vec_t   cur;
   bit     tbl_on = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input int p, input logic v, input logic [W-1:0] b,
                               input logic l, input logic tr, input logic ev,
                               input logic [W-1:0] ed, input logic el, input int ep);
      vec_t t;
      t.v = '0;  t.v[p] = v;
      t.d = '0;  t.d[p*W +: W] = b;
      t.l = '0;  t.l[p] = l;
      t.tr = tr; t.ev = ev; t.ed = ed; t.el = el; t.ep = PW'(ep);
      return t;
   endfunction

   // Compare DUT against the model for this cycle, then advance the model past the next edge.
   task automatic model_check();
      logic [N-1:0] er;
      logic         ev, el;
      logic [W-1:0] ed;
      int           ep, p;
      beat_t        b;
      bit           found;
      if (!resetn) begin
         chk("rst_tx_valid", tx_valid, 0);
         chk("rst_tx_data", tx_data, 0);
         chk("rst_tx_last", tx_last, 0);
         chk("rst_tx_port", tx_port, 0);
         for (int i = 0; i < N; i++) q[i].delete();
         m_mode = 0; m_g = 0; m_rr = N-1;
         acc = '0; in_pkt = 0; prev_v = 0; prev_r = 0;
         return;
      end
      for (int i = 0; i < N; i++) er[i] = (q[i].size() < D);
      chk("rx_ready", rx_ready, er);
      acc = rx_valid & rx_ready;
      ev = 0; ed = '0; el = 0; ep = 0;
      if (m_mode == 1) begin
         ev = 1; ed = W'(m_g); ep = m_g;
      end else if (m_mode == 2) begin
         ep = m_g;
         if (q[m_g].size() > 0) begin
            ev = 1; ed = q[m_g][0][W-1:0]; el = q[m_g][0][W];
         end
      end
      chk("tx_valid", tx_valid, ev);
      chk("tx_port", tx_port, ep);
      if (ev) begin
         chk("tx_data", tx_data, ed);
         chk("tx_last", tx_last, el);
      end
      if (prev_v && !prev_r) begin
         chk("hold_valid", tx_valid, 1);
         chk("hold_data", tx_data, prev_d);
         chk("hold_last", tx_last, prev_l);
      end
      prev_v = tx_valid; prev_r = tx_ready; prev_d = tx_data; prev_l = tx_last;
      if (tx_valid && tx_ready) begin
         if (!in_pkt) begin
            order_q.push_back(int'(tx_port));
            in_pkt = 1;
         end
         if (tx_last) in_pkt = 0;
         if (m_mode == 2) tx_cnt++;
      end
      case (m_mode)
         0: begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
               p = (m_rr + k) % N;
               if (!found && q[p].size() > 0) begin
                  found = 1; m_g = p; m_mode = GRANT_MODE;
               end
            end
         end
         1: if (tx_ready) m_mode = 2;
         default: begin
            if (ev && tx_ready) begin
               b = q[m_g].pop_front();
               if (b[W]) begin
                  m_rr = m_g; m_mode = 0;
               end
            end
         end
      endcase
      for (int i = 0; i < N; i++)
         if (rx_valid[i] && er[i]) q[i].push_back({rx_last[i], rx_data[i*W +: W]});
   endtask

   task automatic cycle();
      @(negedge clk);
      model_check();
      if (tbl_on) begin
         chk("tbl_valid", tx_valid, cur.ev);
         chk("tbl_port", tx_port, cur.ep);
         if (cur.ev) begin
            chk("tbl_data", tx_data, cur.ed);
            chk("tbl_last", tx_last, cur.el);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      for (int i = 0; i < N; i++) src[i].delete();
      rx_valid = '0; rx_last = '0; rx_data = '0; tx_ready = 1'b1;
      resetn = 1'b0;
      cycle();
      cycle();
      resetn = 1'b1;
   endtask

   task automatic gen_pkt(input int p, input int len);
      for (int j = 0; j < len; j++)
         src[p].push_back({(j == len-1), W'($urandom_range(0, 255))});
   endtask

   // vmode: 0 always offer, 1 random gaps. rmode: 0 ready=1, 1 random, 2 ready=0, 3 toggle.
   task automatic run(input int n, input int vmode, input int rmode);
      for (int c = 0; c < n; c++) begin
         for (int i = 0; i < N; i++) begin
            if (src[i].size() > 0 && (vmode == 0 || $urandom_range(0, 3) != 0)) begin
               rx_valid[i] = 1'b1;
               rx_data[i*W +: W] = src[i][0][W-1:0];
               rx_last[i] = src[i][0][W];
            end else begin
               rx_valid[i] = 1'b0;
               rx_data[i*W +: W] = W'($urandom_range(0, 255));
               rx_last[i] = 1'($urandom_range(0, 1));
            end
         end
         case (rmode)
            0: tx_ready = 1'b1;
            1: tx_ready = 1'($urandom_range(0, 1));
            2: tx_ready = 1'b0;
            default: tx_ready = ~tx_ready;
         endcase
         cycle();
         for (int i = 0; i < N; i++)
            if (acc[i]) void'(src[i].pop_front());
      end
      rx_valid = '0;
   endtask

   initial begin
      int total;
      resetn = 1'b0;
      rx_valid = '0; rx_data = '0; rx_last = '0; tx_ready = 1'b1;
      m_mode = 0; m_g = 0; m_rr = N-1; acc = '0; in_pkt = 0; tx_cnt = 0;
      prev_v = 0; prev_r = 0; prev_d = '0; prev_l = 0;

`ifdef PORT_TAG_EN
      tbl[0] = mk(3, 1, 8'h11, 0, 1, 0, 8'h00, 0, 0);
      tbl[1] = mk(3, 1, 8'h22, 0, 1, 0, 8'h00, 0, 0);
      tbl[2] = mk(3, 1, 8'h33, 1, 1, 1, 8'h03, 0, 3);
      tbl[3] = mk(3, 0, 8'h00, 0, 1, 1, 8'h11, 0, 3);
      tbl[4] = mk(3, 0, 8'h00, 0, 1, 1, 8'h22, 0, 3);
      tbl[5] = mk(3, 0, 8'h00, 0, 1, 1, 8'h33, 1, 3);
      tbl[6] = mk(3, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0);
`else
      tbl[0] = mk(2, 1, 8'h11, 0, 1, 0, 8'h00, 0, 0);
      tbl[1] = mk(2, 1, 8'h22, 0, 1, 0, 8'h00, 0, 0);
      tbl[2] = mk(2, 1, 8'h33, 1, 1, 1, 8'h11, 0, 2);
      tbl[3] = mk(2, 0, 8'h00, 0, 1, 1, 8'h22, 0, 2);
      tbl[4] = mk(2, 0, 8'h00, 0, 1, 1, 8'h33, 1, 2);
      tbl[5] = mk(2, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0);
      tbl[6] = mk(2, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0);
`endif

      // single packet, fixed latency
      do_reset();
      for (int r = 0; r < 7; r++) begin
         cur = tbl[r];
         rx_valid = cur.v; rx_data = cur.d; rx_last = cur.l; tx_ready = cur.tr;
         tbl_on = 1;
         cycle();
         tbl_on = 0;
      end
      rx_valid = '0;

      // three ports contend at once; port 0 holds a second packet behind the first
      do_reset();
      order_q.delete();
      gen_pkt(0, 2); gen_pkt(0, 2); gen_pkt(1, 2); gen_pkt(3, 2);
      run(30, 0, 0);
      chk("order_len", order_q.size(), 4);
      if (order_q.size() == 4) begin
         chk("order_0", order_q[0], 0);
         chk("order_1", order_q[1], 1);
         chk("order_2", order_q[2], 3);
         chk("order_3", order_q[3], 0);
      end

      // port 1 fills its FIFO while output is stalled
      do_reset();
      tx_cnt = 0;
      gen_pkt(1, 17);
      run(20, 0, 2);
      chk("full_rx_ready", rx_ready[1], 0);
      chk("full_left", src[1].size(), 1);
      run(40, 0, 0);
      chk("full_drained", src[1].size(), 0);
      chk("full_beats", tx_cnt, 17);

      // backpressure toggling mid-packet
      do_reset();
      tx_cnt = 0;
      gen_pkt(2, 6);
      run(30, 0, 3);
      chk("toggle_beats", tx_cnt, 6);

      // reset in the middle of a packet
      do_reset();
      gen_pkt(0, 4);
      run(2, 0, 0);
      src[0].delete();
      resetn = 1'b0;
      cycle();
      resetn = 1'b1;
      tx_cnt = 0;
      run(6, 0, 0);
      chk("rst_no_beats", tx_cnt, 0);
      gen_pkt(0, 3);
      run(15, 0, 0);
      chk("rst_new_pkt", tx_cnt, 3);

      // randomized traffic
      for (int it = 0; it < 3; it++) begin
         do_reset();
         for (int p = 0; p < N; p++)
            for (int k = 0; k < 5; k++) gen_pkt(p, $urandom_range(1, 5));
         run(300, 1, 1);
         run(200, 0, 0);
         total = 0;
         for (int p = 0; p < N; p++) total += src[p].size() + q[p].size();
         chk("rand_drain", total, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
